// File: rtl/display_pkg.sv
// Shared constants, scan state encoding and digit helpers for the multiplexed
// four-digit display scanner.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Registered snapshot of the scanner's internal state for external checkers.
    typedef struct packed {
        scan_state_t      state;
        logic [IDX_W-1:0] digit;
        logic             pending;
    } scan_dbg_t;

    function automatic logic [DIGIT_W-1:0] nibble(input logic [VALUE_W-1:0] v,
                                                  input logic [IDX_W-1:0]   idx);
        return v[int'(idx)*DIGIT_W +: DIGIT_W];
    endfunction

    // A digit is a leading zero when it and every more significant digit are
    // zero; the rightmost digit always stays lit so 0 shows as "0".
    function automatic logic lz_blank(input logic [VALUE_W-1:0] v,
                                      input logic [IDX_W-1:0]   idx);
        logic blank;
        blank = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && v[i*DIGIT_W +: DIGIT_W] != '0) begin
                blank = 1'b0;
            end
        end
        return blank;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] digit_enable_n(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot timebase: a free-running counter of CLK_DIV cycles per digit slot with
// decoded strobes marking the slot boundaries and the end of the ghost guard.
module scan_tick_gen #(
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start,
    output logic drive_start,
    output logic slot_end
);

    localparam int             CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // slot_start marks the first cycle of a slot. drive_start and slot_end mark
    // the last cycle before the boundary, so registered outputs switch exactly on it.
    assign slot_start  = (count == '0);
    assign drive_start = (count == GAP_LAST);
    assign slot_end    = (count == LAST);

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with ghost-guard gaps, frame-aligned
// (tear-free) value updates and optional leading-zero blanking.
module display_scanner
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [DIGIT_W-1:0]    digit_value,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  digit_blank,
    output scan_dbg_t             dbg
);

    logic slot_start;
    logic drive_start;
    logic slot_end;

    scan_tick_gen #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_start  (slot_start),
        .drive_start (drive_start),
        .slot_end    (slot_end)
    );

    scan_state_t        state;
    logic [IDX_W-1:0]   digit;
    logic [VALUE_W-1:0] shadow;
    logic [VALUE_W-1:0] pending_value;
    logic               pending;

    logic               frame_end;
    logic               commit;
    logic [IDX_W-1:0]   next_digit;
    logic [VALUE_W-1:0] shadow_next;

    // Load handshake: load is a single-cycle request with no back-pressure;
    // the value is held pending (last request wins) and becomes the displayed
    // value only at a frame boundary, which load_ack reports one cycle later.
    always_comb begin
        frame_end   = slot_end && (digit == IDX_W'(NUM_DIGITS - 1));
        next_digit  = digit + IDX_W'(1);
        commit      = frame_end && (load || pending);
        shadow_next = shadow;
        if (frame_end) begin
            if (load) begin
                shadow_next = value;
            end else if (pending) begin
                shadow_next = pending_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            pending_value <= '0;
            pending       <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            load_ack <= commit;
            shadow   <= shadow_next;
            // A load on the frame-end cycle bypasses pending and discards it.
            if (frame_end) begin
                pending <= 1'b0;
            end else if (load) begin
                pending_value <= value;
                pending       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_GUARD;
            digit       <= '0;
            digit_en_n  <= '1;
            digit_value <= '0;
            digit_blank <= 1'b0;
        end else begin
            case (state)
                ST_GUARD: begin
                    if (drive_start) begin
                        state      <= ST_DRIVE;
                        digit_en_n <= digit_enable_n(digit);
                    end
                end
                ST_DRIVE: begin
                    // Next slot's digit data is loaded with the guard so it is
                    // stable before any enable goes low.
                    if (slot_end) begin
                        state       <= ST_GUARD;
                        digit       <= next_digit;
                        digit_en_n  <= '1;
                        digit_value <= nibble(shadow_next, next_digit);
                        digit_blank <= blank_lz && lz_blank(shadow_next, next_digit);
                    end
                end
            endcase
        end
    end

    assign dbg = '{state: state, digit: digit, pending: pending};

    slot_start_in_guard: assert property (
        @(posedge clk) disable iff (!rst_n) slot_start |-> state == ST_GUARD
    );

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with CLK_DIV=8, GAP_CYCLES=2.
`timescale 1ns/1ps
module tb_display_scanner;
    import display_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int GAP     = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] nib;
        logic       blank;
    } slot_rec_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] value    = 16'h0;
    logic        blank_lz = 1'b0;
    logic        load_ack;
    logic [3:0]  digit_value;
    logic [3:0]  digit_en_n;
    logic        digit_blank;
    scan_dbg_t   dbg;

    slot_rec_t   exp_q[$];
    int          ack_q[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          cyc    = 0;
    bit          mon_on = 1'b0;
    logic [15:0] shown   = 16'h0;
    logic        blz_cur = 1'b0;
    slot_rec_t   cur     = '0;

    display_scanner #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .blank_lz    (blank_lz),
        .load_ack    (load_ack),
        .digit_value (digit_value),
        .digit_en_n  (digit_en_n),
        .digit_blank (digit_blank),
        .dbg         (dbg)
    );

    // clock / cycle index since reset release
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_blank(input logic [15:0] v, input int i, input logic blz);
        if (!blz || i == 0) return 1'b0;
        return (v >> (4 * i)) == 16'h0;
    endfunction

    // monitor: slot records popped at each slot start, load_ack pops ack queue
    always @(negedge clk) begin : monitor
        int         off;
        logic [3:0] en_exp;
        int         ack_exp;
        if (mon_on) begin
            off = cyc % CLK_DIV;
            if (off == 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL slot_queue cyc=%0d: got empty queue, expected a slot record", cyc);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            en_exp = (off < GAP) ? 4'b1111 : ~(4'b0001 << cur.idx);
            check("digit_en_n",  16'(digit_en_n),  16'(en_exp));
            check("digit_value", 16'(digit_value), 16'(cur.nib));
            check("digit_blank", 16'(digit_blank), 16'(cur.blank));
            check("dbg_state",   16'(dbg.state),   (off < GAP) ? 16'(ST_GUARD) : 16'(ST_DRIVE));
        end
        if (load_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL load_ack cyc=%0d: got unexpected pulse, expected none", cyc);
            end else begin
                ack_exp = ack_q.pop_front();
                check("load_ack_cycle", 16'(cyc), 16'(ack_exp));
            end
        end
    end

    // driver: runs one frame from its offset-0 cycle, pushing the four slots it
    // should show and the ack its loads should earn at the next frame start
    task automatic run_frame(input int ncyc,
                             input int l0_off, input logic [15:0] l0_val,
                             input int l1_off, input logic [15:0] l1_val,
                             input logic blz_next);
        int          base;
        bit          loaded;
        logic [15:0] last;
        slot_rec_t   r;
        base   = cyc;
        loaded = 1'b0;
        last   = shown;
        for (int i = 0; i < 4; i++) begin
            r.idx   = 2'(i);
            r.nib   = shown[4*i +: 4];
            r.blank = exp_blank(shown, i, blz_cur);
            exp_q.push_back(r);
        end
        for (int off = 0; off < ncyc; off++) begin
            if (off == FRAME - 1) blank_lz = blz_next;
            if (off == l0_off) begin load = 1'b1; value = l0_val; loaded = 1'b1; last = l0_val; end
            if (off == l1_off) begin load = 1'b1; value = l1_val; loaded = 1'b1; last = l1_val; end
            @(posedge clk);
            #2;
            load = 1'b0;
        end
        if (ncyc == FRAME) begin
            if (loaded) ack_q.push_back(base + FRAME);
            shown   = last;
            blz_cur = blz_next;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_on = 1'b1;
        run_frame(FRAME, -1, 16'h0000, -1, 16'h0000, 1'b0);   // idle after reset
        run_frame(FRAME,  5, 16'h1234, -1, 16'h0000, 1'b0);   // mid-frame load
        run_frame(FRAME,  3, 16'hAAAA, 20, 16'h00F5, 1'b0);   // last load wins
        run_frame(FRAME,  8, 16'h9999, 31, 16'h0070, 1'b0);   // frame-end load
        run_frame(FRAME, -1, 16'h0000, -1, 16'h0000, 1'b1);
        run_frame(FRAME, 10, 16'h0000, -1, 16'h0000, 1'b1);   // 0070 blanked
        run_frame(FRAME,  0, 16'h0305, -1, 16'h0000, 1'b1);   // 0000 blanked
        run_frame(FRAME, -1, 16'h0000, -1, 16'h0000, 1'b0);   // 0305 blanked
        run_frame(19,     4, 16'hBEEF, -1, 16'h0000, 1'b0);   // into DRIVE of digit 2

        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_digit_en_n",  16'(digit_en_n),  16'hF);
        check("rst_digit_value", 16'(digit_value), 16'h0);
        check("rst_digit_blank", 16'(digit_blank), 16'h0);
        check("rst_load_ack",    16'(load_ack),    16'h0);
        check("rst_dbg_state",   16'(dbg.state),   16'(ST_GUARD));
        check("rst_dbg_digit",   16'(dbg.digit),   16'h0);
        check("rst_dbg_pending", 16'(dbg.pending), 16'h0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        shown   = 16'h0000;
        blz_cur = blank_lz;
        mon_on  = 1'b1;
        run_frame(FRAME, -1, 16'h0000, -1, 16'h0000, 1'b0);
        run_frame(FRAME, -1, 16'h0000, -1, 16'h0000, 1'b0);
        mon_on = 1'b0;

        check("ack_outstanding",  16'(ack_q.size()), 16'h0);
        check("slot_outstanding", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
